// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants: default word width and FIFO address width used by the receiver,
// the baud-tick generator and the receive FIFO.
package uart_rx_fifo_pkg;

    localparam int unsigned DBIT_DEF   = 8;
    localparam int unsigned ADDR_W_DEF = 4;

    function automatic int unsigned fifo_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer, occupancy count and empty/full status for the UART receive FIFO.
module fifo_ctrl
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] FullCount = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   count_q, count_d;
    logic              empty_q, full_q;
    logic              rd_en;

    // A full FIFO still accepts a write when the same cycle pops the head.
    assign wr_en = wr & (~full_q | rd);
    assign rd_en = rd & ~empty_q;

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == FullCount);
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign empty  = empty_q;
    assign full   = full_q;
    assign count  = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind a UART receiver.
// Sticky overrun flag (ovr/clr_ovr) is built only with UART_RX_FIFO_OVR_EN defined.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DBIT   = DBIT_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_done_tick,
    input  logic [DBIT-1:0]   din,
    input  logic              rd,
    output logic [DBIT-1:0]   dout,
    output logic              empty,
    output logic              full,
`ifdef UART_RX_FIFO_OVR_EN
    input  logic              clr_ovr,
    output logic              ovr,
`endif
    output logic [ADDR_W:0]   count
);

    localparam int unsigned Depth = fifo_depth(ADDR_W);

    logic [DBIT-1:0]   mem_q [Depth];
    logic              wr_en;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;

    fifo_ctrl #(
        .ADDR_W (ADDR_W)
    ) u_ctrl (
        .clk    (clk),
        .reset  (reset),
        .wr     (rx_done_tick),
        .rd     (rd),
        .wr_en  (wr_en),
        .wr_ptr (wr_ptr),
        .rd_ptr (rd_ptr),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr] <= din;
        end
    end

    assign dout = mem_q[rd_ptr];

`ifdef UART_RX_FIFO_OVR_EN
    logic ovr_q;
    logic drop;

    assign drop = rx_done_tick & full & ~rd;

    // Set beats clear so a drop is never lost to a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset)        ovr_q <= 1'b0;
        else if (drop)    ovr_q <= 1'b1;
        else if (clr_ovr) ovr_q <= 1'b0;
    end

    assign ovr = ovr_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (default 8-bit x 16 entries); ovr checks when
// UART_RX_FIFO_OVR_EN is defined.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] din = 8'h00;
    logic       rd = 1'b0;
    logic [7:0] dout;
    logic       empty, full;
    logic [4:0] count;
`ifdef UART_RX_FIFO_OVR_EN
    logic       clr_ovr = 1'b0;
    logic       ovr;
`endif

    int checks = 0;
    int errors = 0;

    uart_rx_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .din          (din),
        .rd           (rd),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
`ifdef UART_RX_FIFO_OVR_EN
        .clr_ovr      (clr_ovr),
        .ovr          (ovr),
`endif
        .count        (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rx;
        logic [7:0] din;
        logic       rd;
        int         cnt;
        logic       emp;
        logic       ful;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[9];
    logic [7:0] model_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic r_x, input logic [7:0] d, input logic r_d);
        rx_done_tick = r_x;
        din = d;
        rd = r_d;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
        rd = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_status(input string tag, input int cnt, input logic emp, input logic ful);
        check({tag, " count"}, 32'(count), 32'(cnt));
        check({tag, " empty"}, 32'(empty), 32'(emp));
        check({tag, " full"}, 32'(full), 32'(ful));
    endtask

    initial begin
        // {rx, din, rd, count, empty, full, dout} after each edge, from a clean reset
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1, 1'b0, 1'b0, 8'hA5};
        vecs[1] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
        vecs[3] = '{1'b1, 8'h3C, 1'b1, 1, 1'b0, 1'b0, 8'h3C};
        vecs[4] = '{1'b1, 8'h11, 1'b0, 2, 1'b0, 1'b0, 8'h3C};
        vecs[5] = '{1'b1, 8'h22, 1'b1, 2, 1'b0, 1'b0, 8'h11};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 8'h22};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 8'h00};
        vecs[8] = '{1'b0, 8'hFF, 1'b0, 0, 1'b1, 1'b0, 8'h00};

        @(posedge clk);
        do_reset();
        check_status("reset", 0, 1'b1, 1'b0);
        check("reset dout", 32'(dout), 32'h0);
`ifdef UART_RX_FIFO_OVR_EN
        check("reset ovr", 32'(ovr), 32'h0);
`endif

        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rx, vecs[i].din, vecs[i].rd);
            check_status($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].emp, vecs[i].ful);
            check($sformatf("vec%0d dout", i), 32'(dout), 32'(vecs[i].dout));
        end

        // Fill to 16, then drain in order.
        do_reset();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        check_status("fill", 16, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain dout%0d", i), 32'(dout), 32'(i));
            step(1'b0, 8'h00, 1'b1);
        end
        check_status("drained", 0, 1'b1, 1'b0);

        // Drop while full, then push+pop while full.
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        step(1'b1, 8'h55, 1'b0);
        check_status("drop", 16, 1'b0, 1'b1);
        check("drop head", 32'(dout), 32'h00);
`ifdef UART_RX_FIFO_OVR_EN
        check("drop ovr", 32'(ovr), 32'h1);
        clr_ovr = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        clr_ovr = 1'b0;
        check("clr ovr", 32'(ovr), 32'h0);
        clr_ovr = 1'b1;
        step(1'b1, 8'h66, 1'b0);
        clr_ovr = 1'b0;
        check("set wins ovr", 32'(ovr), 32'h1);
        clr_ovr = 1'b1;
        step(1'b0, 8'h00, 1'b0);
        clr_ovr = 1'b0;
        check("clr ovr again", 32'(ovr), 32'h0);
`endif
        step(1'b1, 8'h77, 1'b1);
        check_status("full rw", 16, 1'b0, 1'b1);
        check("full rw head", 32'(dout), 32'h01);
`ifdef UART_RX_FIFO_OVR_EN
        check("full rw ovr", 32'(ovr), 32'h0);
`endif
        for (int i = 1; i < 16; i++) begin
            check($sformatf("rw drain %0d", i), 32'(dout), 32'(i));
            step(1'b0, 8'h00, 1'b1);
        end
        check("rw last", 32'(dout), 32'h77);
        step(1'b0, 8'h00, 1'b1);
        check_status("rw empty", 0, 1'b1, 1'b0);

        // 20 pushes interleaved with pops; pointers wrap past 16.
        do_reset();
        model_q.delete();
        for (int i = 0; i < 20; i++) begin
            logic do_rd;
            do_rd = (i % 3 != 0);
            if (do_rd && model_q.size() != 0) begin
                check($sformatf("wrap dout%0d", i), 32'(dout), 32'(model_q[0]));
                void'(model_q.pop_front());
            end
            model_q.push_back(8'h80 + 8'(i));
            step(1'b1, 8'h80 + 8'(i), do_rd);
        end
        check("wrap count", 32'(count), 32'(model_q.size()));
        while (model_q.size() != 0) begin
            check("wrap tail", 32'(dout), 32'(model_q[0]));
            void'(model_q.pop_front());
            step(1'b0, 8'h00, 1'b1);
        end
        check_status("wrap empty", 0, 1'b1, 1'b0);

        // Mid-stream reset with count=5 and overrun pending.
        for (int i = 0; i < 16; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0);
        step(1'b1, 8'hEE, 1'b0);
        for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1);
        check_status("pre reset", 5, 1'b0, 1'b0);
        check("pre reset dout", 32'(dout), 32'hCB);
        reset = 1'b1;
`ifdef UART_RX_FIFO_OVR_EN
        check("pre reset ovr", 32'(ovr), 32'h1);
`endif
        step(1'b1, 8'h99, 1'b1);
        reset = 1'b0;
        check_status("mid reset", 0, 1'b1, 1'b0);
        check("mid reset dout", 32'(dout), 32'h0);
`ifdef UART_RX_FIFO_OVR_EN
        check("mid reset ovr", 32'(ovr), 32'h0);
`endif
        step(1'b0, 8'h00, 1'b1);
        check_status("rd empty", 0, 1'b1, 1'b0);
        check("rd empty dout", 32'(dout), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning data word width in bits (matches receiver dout width).
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning log2 of FIFO depth (default 16 entries).
REQ-003 The block SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port rx_done_tick  input  1  one-cycle write strobe from the UART receiver.
REQ-006 The block SHALL have port din  input  DBIT  received byte, valid when rx_done_tick=1.
REQ-007 The block SHALL have port rd  input  1  consumer pop request, one entry per cycle asserted.
REQ-008 The block SHALL have port dout  output  DBIT  head entry, first-word-fall-through.
REQ-009 The block SHALL have port empty  output  1  FIFO holds zero entries.
REQ-010 The block SHALL have port full  output  1  FIFO holds 2**ADDR_W entries.
REQ-011 The block SHALL have port count  output  ADDR_W+1  current number of entries.
REQ-012 The block SHALL have ports ovr  output  1  sticky overrun flag, and clr_ovr  input  1  clears ovr (both present only per REQ-027).

Function
REQ-013 The block SHALL push din when rx_done_tick=1 and (full=0 or rd=1), storing it at the write pointer.
REQ-014 The block SHALL pop when rd=1 and empty=0, advancing the read pointer.
REQ-015 The block SHALL present dout combinationally from the entry at the read pointer; dout SHALL show a written byte in the cycle after its push edge (write-to-dout latency 1 clock).
REQ-016 The block SHALL wrap both pointers modulo 2**ADDR_W, with no gap or duplicate at wrap-around.
REQ-017 The block SHALL update count, empty, full registered on the same edge as the push/pop: +1 push only, -1 pop only, unchanged for both or neither.
REQ-018 The block SHALL ignore rd when empty=1 (no pointer move, no count change, no error).
REQ-019 The block SHALL, when empty=1 and rx_done_tick=rd=1, perform the push only.
REQ-020 The block SHALL, when full=1 and rx_done_tick=rd=1, perform both pop and push; count stays 2**ADDR_W; no overrun.
REQ-021 The block SHALL, when full=1, rx_done_tick=1, rd=0, drop din and leave storage, pointers and count unchanged.
REQ-022 The block SHALL hold empty=1 exactly when count=0 and full=1 exactly when count=2**ADDR_W.

Reset
REQ-023 The block SHALL, on reset=1 at a clock edge, set pointers=0, count=0, empty=1, full=0, ovr=0 and clear all storage to 0, so dout=0.
REQ-024 The block SHALL give reset priority over any simultaneous rx_done_tick, rd or clr_ovr, discarding all stored data, including in mid-stream.

Configuration
REQ-025 The block SHALL compile the overrun-detection feature under the macro UART_RX_FIFO_OVR_EN.
REQ-026 With UART_RX_FIFO_OVR_EN defined, the block SHALL set ovr=1 on the edge after a drop (REQ-021) and hold it until clr_ovr=1 or reset; a drop with clr_ovr=1 in the same cycle SHALL leave ovr=1 (set wins).
REQ-027 Without UART_RX_FIFO_OVR_EN, ports ovr and clr_ovr SHALL be absent and drops SHALL be silent; all other behaviour identical.

Structure
REQ-028 The shared UART package/include file SHALL hold the DBIT and ADDR_W default constants, shared with uart_rx and the baud-tick generator.
REQ-029 Pointer, count and status logic SHALL live in one sub-module fifo_ctrl; uart_rx_fifo SHALL contain only the storage array, dout mux and overrun flag.

Verification
REQ-030 Bench SHALL apply reset, then push 0xA5 -> next cycle dout=0xA5, count=1, empty=0; rd one cycle -> empty=1, count=0.
REQ-031 Bench SHALL push 16 bytes 0x00..0x0F with rd=0 -> full=1, count=16; pop 16 -> dout sequence 0x00..0x0F, then empty=1.
REQ-032 Bench SHALL, at full, push 0x55 with rd=0 -> count=16, head still 0x00, ovr=1 (macro on); pulse clr_ovr -> ovr=0.
REQ-033 Bench SHALL, at full, assert rx_done_tick=rd=1 with din=0x77 -> count=16, ovr=0, 0x77 read out last.
REQ-034 Bench SHALL push 20 bytes interleaved with pops so the pointers wrap -> FIFO order preserved, no data loss.
REQ-035 Bench SHALL assert reset with count=5 -> next cycle count=0, empty=1, dout=0, ovr=0; rd on empty -> no change.
